// File: rtl/alu_pkg.sv
// Shared definitions for the ALU datapath and its multi-cycle multiply/divide unit.
// Provides the M-extension opcode encoding, the muldiv FSM state type, the
// {N,Z,C,V} status bit positions used by both units, and small decode helpers.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_MUL    = 4'b0000,
      OP_MULH   = 4'b0001,
      OP_MULHSU = 4'b0010,
      OP_MULHU  = 4'b0011,
      OP_DIV    = 4'b0100,
      OP_DIVU   = 4'b0101,
      OP_REM    = 4'b0110,
      OP_REMU   = 4'b0111
   } md_op_e;

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} md_state_e;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   function automatic logic op_is_div(input md_op_e op);
      return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
   endfunction

   // Operand A is two's complement for every signed flavour, including MULHSU.
   function automatic logic op_a_signed(input md_op_e op);
      return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
   endfunction

   // MULHSU treats B as unsigned.
   function automatic logic op_b_signed(input md_op_e op);
      return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
   endfunction

   function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                             input logic c, input logic v);
      logic [3:0] f;
      f         = '0;
      f[FLAG_N] = n;
      f[FLAG_Z] = z;
      f[FLAG_C] = c;
      f[FLAG_V] = v;
      return f;
   endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Combinational single-step datapath of the multiply/divide unit.
// Multiply: one radix-2 shift-add step on a {high, low} accumulator whose low
//           half holds the remaining multiplier bits.
// Divide:   one restoring-divide step on a {remainder, dividend/quotient}
//           accumulator, using a C_WIDTH+1-bit partial remainder.
// Ports:
//   is_div_i  step type (1 = divide, 0 = multiply)
//   acc_i     current 2*C_WIDTH-bit accumulator
//   opb_i     multiplicand (multiply) or divisor (divide) magnitude
//   acc_o     accumulator after one step
module muldiv_iter
   import alu_pkg::*;
#(
   parameter int C_WIDTH = 32
) (
   input  logic                 is_div_i,
   input  logic [2*C_WIDTH-1:0] acc_i,
   input  logic [C_WIDTH-1:0]   opb_i,
   output logic [2*C_WIDTH-1:0] acc_o
);
   localparam int W = C_WIDTH;

   logic [W:0]   add_sum;
   logic [W:0]   shifted;
   logic [W-1:0] diff;
   logic         ge;

   // NOTE: every signal driven here gets a value on all paths, so no latch is inferred.
   always_comb begin
      // Multiply: add the multiplicand when the current multiplier bit is set,
      // then shift the whole accumulator right with the carry moving into the top.
      add_sum = {1'b0, acc_i[2*W-1:W]} + (acc_i[0] ? {1'b0, opb_i} : '0);
      // Divide: bring the next dividend bit into the partial remainder.
      shifted = {acc_i[2*W-1:W], acc_i[W-1]};
      ge      = shifted >= {1'b0, opb_i};
      // When ge holds, the difference is below the divisor and fits in W bits.
      diff    = shifted[W-1:0] - opb_i;
      if (is_div_i) begin
         acc_o = {(ge ? diff : shifted[W-1:0]), acc_i[W-2:0], ge};
      end else begin
         acc_o = {add_sum, acc_i[W-1:1]};
      end
   end

endmodule

// File: rtl/alu_muldiv.sv
// Multi-cycle RV32M-style multiply/divide unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
// Operands are converted to magnitudes on acceptance, iterated for C_WIDTH cycles,
// sign-corrected in a FIX cycle, then held until the consumer takes the result.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  request handshake (in_ready high only in IDLE)
//   A, B, opcode         operands and operation (1xxx is illegal)
//   flush                abort any in-flight or pending operation
//   out_valid/out_ready  result handshake
//   Result, Status       result and {N,Z,C,V} flags, stable while out_valid
module alu_muldiv
   import alu_pkg::*;
#(
   parameter int C_WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [C_WIDTH-1:0] A,
   input  logic [C_WIDTH-1:0] B,
   input  logic [3:0]         opcode,
   input  logic               flush,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [C_WIDTH-1:0] Result,
   output logic [3:0]         Status
);
   localparam int           W       = C_WIDTH;
   localparam int           CNT_W   = $clog2(C_WIDTH + 1);
   localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

   md_state_e        state_q;
   md_op_e           op_q;
   logic [CNT_W-1:0] cnt_q;
   logic             neg_q;      // negate product / quotient
   logic             neg_rem_q;  // remainder takes the sign of A
   logic [2*W-1:0]   acc_q;
   logic [W-1:0]     opb_q;
   logic [W-1:0]     corr_q;     // signed-to-unsigned high-half correction for MUL
   logic [W-1:0]     result_q;
   logic [3:0]       status_q;
   logic             out_valid_q;

   // Acceptance-side decode
   md_op_e       op_in;
   logic         illegal;
   logic         a_neg;
   logic         b_neg;
   logic [W-1:0] a_mag;
   logic [W-1:0] b_mag;
   logic         special;
   logic [W-1:0] sp_res;
   logic         sp_c;
   logic         sp_v;

   always_comb begin
      op_in   = md_op_e'(opcode);
      illegal = opcode[3];
      a_neg   = op_a_signed(op_in) && A[W-1];
      b_neg   = op_b_signed(op_in) && B[W-1];
      a_mag   = a_neg ? -A : A;
      b_mag   = b_neg ? -B : B;
      special = 1'b0;
      sp_res  = '0;
      sp_c    = 1'b0;
      sp_v    = 1'b0;
      if (illegal) begin
         special = 1'b1;  // Result 0 makes the generic flags come out as 4'b0100
      end else if (op_is_div(op_in) && (B == '0)) begin
         special = 1'b1;
         sp_c    = 1'b1;
         sp_res  = (op_in == OP_DIV || op_in == OP_DIVU) ? '1 : A;
      end else if ((op_in == OP_DIV || op_in == OP_REM) && (A == MIN_NEG) && (B == '1)) begin
         special = 1'b1;
         sp_v    = 1'b1;
         sp_res  = (op_in == OP_DIV) ? A : '0;
      end
   end

   // Iteration step
   logic           is_div_q;
   logic [2*W-1:0] iter_acc;

   assign is_div_q = op_is_div(op_q);

   muldiv_iter #(.C_WIDTH(W)) u_iter (
      .is_div_i (is_div_q),
      .acc_i    (acc_q),
      .opb_i    (opb_q),
      .acc_o    (iter_acc)
   );

   // Sign fix-up and half selection
   logic [2*W-1:0] prod;
   logic [W-1:0]   quo;
   logic [W-1:0]   rem;
   logic [W-1:0]   hi_u;
   logic [W-1:0]   fx_res;
   logic           fx_c;
   logic           fx_v;

   always_comb begin
      prod   = neg_q ? -acc_q : acc_q;
      quo    = neg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
      rem    = neg_rem_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
      // High half of the unsigned product = signed high half + (A<0 ? B : 0) + (B<0 ? A : 0).
      hi_u   = prod[2*W-1:W] + corr_q;
      fx_res = '0;
      fx_c   = 1'b0;
      fx_v   = 1'b0;
      case (op_q)
         OP_MUL: begin
            fx_res = prod[W-1:0];
            fx_c   = |hi_u;
            // Representable only if the top W+1 bits are a pure sign extension.
            fx_v   = !((&prod[2*W-1:W-1]) || (~|prod[2*W-1:W-1]));
         end
         OP_MULH, OP_MULHSU, OP_MULHU: fx_res = prod[2*W-1:W];
         OP_DIV, OP_DIVU:              fx_res = quo;
         OP_REM, OP_REMU:              fx_res = rem;
         default:                      fx_res = '0;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         op_q        <= OP_MUL;
         cnt_q       <= '0;
         neg_q       <= 1'b0;
         neg_rem_q   <= 1'b0;
         acc_q       <= '0;
         opb_q       <= '0;
         corr_q      <= '0;
         result_q    <= '0;
         status_q    <= '0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid && !flush) begin
                  op_q      <= op_in;
                  neg_q     <= a_neg ^ b_neg;
                  neg_rem_q <= a_neg;
                  corr_q    <= (a_neg ? B : '0) + (b_neg ? A : '0);
                  if (op_is_div(op_in)) begin
                     acc_q <= {{W{1'b0}}, a_mag};
                     opb_q <= b_mag;
                  end else begin
                     acc_q <= {{W{1'b0}}, b_mag};
                     opb_q <= a_mag;
                  end
                  if (special) begin
                     result_q    <= sp_res;
                     status_q    <= pack_flags(sp_res[W-1], sp_res == '0, sp_c, sp_v);
                     out_valid_q <= 1'b1;
                     state_q     <= DONE;
                  end else begin
                     cnt_q   <= CNT_W'(W);
                     state_q <= CALC;
                  end
               end
            end
            CALC: begin
               if (flush) begin
                  state_q <= IDLE;
               end else begin
                  acc_q <= iter_acc;
                  cnt_q <= cnt_q - CNT_W'(1);
                  if (cnt_q == CNT_W'(1)) state_q <= FIX;
               end
            end
            FIX: begin
               if (flush) begin
                  state_q <= IDLE;
               end else begin
                  result_q    <= fx_res;
                  status_q    <= pack_flags(fx_res[W-1], fx_res == '0, fx_c, fx_v);
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               if (flush || out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = out_valid_q;
   assign Result    = result_q;
   assign Status    = status_q;

endmodule
